cla_pipe_subtractor: RTL and testbench
======================================

// Module: cla_pipe_subtractor
// PURPOSE
//  Pipelined WIDTH-bit subtractor built from 4-bit carry-look-ahead slices: Diff = A - B - Bin.
//  Subtraction is A + ~B + ~Bin through one 4-bit CLA slice per stage; the registered carry is
//  passed slice-to-slice, operands are staggered, results de-skewed. Complements the combinational
//  CLA adder. Serves wide datapaths that need 1 result/cycle at a 4-bit-slice critical path.
// PARAMETERS
//  WIDTH   16   operand/result width; multiple of 4, >= 8; stages NS = WIDTH/4
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      A/B/Bin valid this cycle
//  in_ready   out  1      block accepts operands this cycle
//  A          in   WIDTH  minuend (unsigned or two's complement)
//  B          in   WIDTH  subtrahend
//  Bin        in   1      borrow-in
//  out_valid  out  1      Diff/Bout valid
//  out_ready  in   1      downstream accepts result
//  Diff       out  WIDTH  (A - B - Bin) mod 2^WIDTH
//  Bout       out  1      1 iff A < B + Bin (unsigned); = ~carry-out of final slice
//  Zero       out  1      [SUB_FLAGS_EN only] Diff == 0
//  Ovf        out  1      [SUB_FLAGS_EN only] signed overflow: A[W-1]!=B[W-1] && Diff[W-1]!=A[W-1]
// BEHAVIOUR
//  - Slice k (0..NS-1) in stage k: G=a&~b, P=a^~b per bit, carry-in = ~Bin (k=0) or stage k-1
//    registered carry; 4-bit CLA equations; sum bits = P ^ C.
//  - Stage enable adv = ~out_valid | out_ready; in_ready = adv (combinational). Whole pipe
//    advances together on adv; holds every register when adv=0 (no bubble collapsing).
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - Latency: NS cycles from input transfer to out_valid=1 with pipe unstalled (16 -> 4).
//  - Throughput: 1 result/cycle when out_ready held high; results in input order.
//  - Per-stage valid bit; out_valid = last stage valid. Upper operand nibbles shift
//    alongside in skew registers; lower result nibbles in de-skew registers.
//  - Diff/Bout (and flags) stable while out_valid=1 & out_ready=0.
//  - in_valid=0 inserts a bubble (valid=0); data regs may update, valid bits must be 0.
//  - Reset: all valid bits, carries, data regs, Diff, Bout, Zero, Ovf = 0; in_ready = 1
//    in the first cycle after reset. Reset mid-operation flushes in-flight results (none emitted).
//  - Boundary: A=B, Bin=0 -> Diff=0, Bout=0. A=0,B=0,Bin=1 -> Diff=all-ones, Bout=1.
//    A=all-ones,B=all-ones,Bin=1 -> Diff=all-ones, Bout=1. Simultaneous out transfer and
//    in transfer in the same cycle is legal and must not lose or duplicate data.
// CONFIGURATION
//  SUB_FLAGS_EN defined: Zero and Ovf ports exist, registered with Diff in the final stage,
//    0 at reset, held on stall.
//  SUB_FLAGS_EN undefined: Zero/Ovf ports and logic absent; all other behaviour identical.
// TESTING (WIDTH=16)
//  1. A=0x1234,B=0x0034,Bin=0, out_ready=1 -> 4 cycles later out_valid=1, Diff=0x1200, Bout=0.
//  2. A=0x0000,B=0x0001,Bin=0 -> Diff=0xFFFF, Bout=1; flags: Zero=0, Ovf=0.
//     A=0x8000,B=0x0001 -> Diff=0x7FFF, Bout=0, Ovf=1. A=0x0005,B=0x0003,Bin=1 -> Diff=0x0001.
//  3. 16 back-to-back operand pairs, out_ready=1 -> 16 consecutive out_valid cycles,
//     results in order, equal to (A-B-Bin)&0xFFFF; random 10k vectors vs model.
//  4. Pipe full, out_ready=0 for 5 cycles -> in_ready=0, Diff/Bout frozen; release ->
//     flow resumes with no loss/duplication; random out_ready toggling with in_valid.
//  5. rst=1 for 1 cycle with 3 results in flight -> next cycle out_valid=0, Diff=0,
//     in_ready=1; no stale results emitted afterwards.
//  6. Build with and without SUB_FLAGS_EN -> Diff/Bout streams identical; A=B=0x5A5A ->
//     Zero=1, Ovf=0.

Source files
------------

// File: rtl/cla_pipe_subtractor.sv
// Pipelined WIDTH-bit subtractor: Diff = A - B - Bin, one 4-bit CLA slice per stage.
// Optional build macro SUB_FLAGS_EN adds registered Zero / Ovf result flags.
module cla_pipe_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SUB_FLAGS_EN
  ,
  output logic             Zero,
  output logic             Ovf
`endif
);

  localparam int unsigned NS = WIDTH / 4;

  logic             adv;
  logic [NS-1:0]    vld;
  logic [NS-2:0]    cy_q, cy_d;
  logic             bout_q, bout_d;
  logic [WIDTH-1:0] a_q [NS-1];
  logic [WIDTH-1:0] b_q [NS-1];
  logic [WIDTH-1:0] d_q [NS];
  logic [WIDTH-1:0] a_d [NS-1];
  logic [WIDTH-1:0] b_d [NS-1];
  logic [WIDTH-1:0] d_d [NS];
  logic [WIDTH-1:0] sa, sb, sd;
  logic             sc;
  logic [4:0]       r;

  // 4-bit carry-look-ahead on A + ~B + cin; returns {carry_out, sum}
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = a & ~b;
    p    = a ^ ~b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

  assign adv       = ~vld[NS-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld[NS-1];
  assign Diff      = d_q[NS-1];
  assign Bout      = bout_q;

  // Stage k consumes nibble k of the skewed operands; the lower nibbles ride
  // along in d_* so the final stage holds the complete, de-skewed difference.
  always_comb begin
    cy_d   = '0;
    bout_d = 1'b0;
    sa     = '0;
    sb     = '0;
    sd     = '0;
    sc     = 1'b0;
    r      = '0;
    for (int unsigned k = 0; k < NS - 1; k++) begin
      a_d[k] = '0;
      b_d[k] = '0;
    end
    for (int unsigned k = 0; k < NS; k++) begin
      d_d[k] = '0;
    end
    for (int unsigned k = 0; k < NS; k++) begin
      if (k == 0) begin
        sa = A;
        sb = B;
        sd = '0;
        sc = ~Bin;
      end else begin
        sa = a_q[k-1];
        sb = b_q[k-1];
        sd = d_q[k-1];
        sc = cy_q[k-1];
      end
      r                 = cla4(sa[4*k +: 4], sb[4*k +: 4], sc);
      d_d[k]            = sd;
      d_d[k][4*k +: 4]  = r[3:0];
      if (k < NS - 1) begin
        a_d[k]  = sa;
        b_d[k]  = sb;
        cy_d[k] = r[4];
      end else begin
        bout_d  = ~r[4];
      end
    end
  end

`ifdef SUB_FLAGS_EN
  logic zero_q, ovf_q, zero_d, ovf_d;
  assign zero_d = (d_d[NS-1] == '0);
  assign ovf_d  = (a_q[NS-2][WIDTH-1] != b_q[NS-2][WIDTH-1]) &&
                  (d_d[NS-1][WIDTH-1] != a_q[NS-2][WIDTH-1]);
  assign Zero   = zero_q;
  assign Ovf    = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld    <= '0;
      cy_q   <= '0;
      bout_q <= 1'b0;
      for (int unsigned k = 0; k < NS - 1; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int unsigned k = 0; k < NS; k++) begin
        d_q[k] <= '0;
      end
    end else if (adv) begin
      vld    <= {vld[NS-2:0], in_valid};
      cy_q   <= cy_d;
      bout_q <= bout_d;
      for (int unsigned k = 0; k < NS - 1; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
      for (int unsigned k = 0; k < NS; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_subtractor.sv
// Directed self-checking bench for cla_pipe_subtractor (WIDTH=16); flag checks
// are compiled in when SUB_FLAGS_EN is defined.
module tb_cla_pipe_subtractor;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, Bin, out_valid, out_ready, Bout;
  logic [W-1:0] A, B, Diff;
`ifdef SUB_FLAGS_EN
  logic         Zero, Ovf;
`endif

  int tests = 0;
  int fails = 0;
  logic [W:0] q[$];

  always #5 clk = ~clk;

  cla_pipe_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .Diff(Diff), .Bout(Bout)
`ifdef SUB_FLAGS_EN
    , .Zero(Zero), .Ovf(Ovf)
`endif
  );

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic bi);
    logic [W-1:0] d;
    logic         bo;
    d  = a - b - {{(W-1){1'b0}}, bi};
    bo = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, bi}));
    return {bo, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of streaming traffic; reports any output transfer and the
  // scoreboard entry it should match.
  task automatic drive_cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic bi, input logic ordy, output logic popped,
                             output logic extra, output logic [W:0] got,
                             output logic [W:0] exp);
    in_valid  = iv;
    A         = a;
    B         = b;
    Bin       = bi;
    out_ready = ordy;
    #1;
    popped = out_valid & out_ready;
    extra  = 1'b0;
    got    = {Bout, Diff};
    exp    = '0;
    if (popped) begin
      if (q.size() == 0) extra = 1'b1;
      else exp = q.pop_front();
    end
    if (iv && in_ready) q.push_back(model(a, b, bi));
    step();
  endtask

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         output int lat, output logic [W-1:0] d, output logic bo,
                         output logic z, output logic ov);
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    Bin       = bi;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    d  = Diff;
    bo = Bout;
`ifdef SUB_FLAGS_EN
    z  = Zero;
    ov = Ovf;
`else
    z  = 1'b0;
    ov = 1'b0;
`endif
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Bin = 1'b0;
    step();
    step();
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || Diff !== 16'h0000 || Bout !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: out_valid=%b Diff=%h Bout=%b in_ready=%b, want 0 0000 0 1",
               out_valid, Diff, Bout, in_ready);
    end
`ifdef SUB_FLAGS_EN
    tests++;
    if (Zero !== 1'b0 || Ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: Zero=%b Ovf=%b, want 0 0", Zero, Ovf);
    end
`endif
  endtask

  task automatic test_boundary();
    logic [W-1:0] av  [8] = '{16'h1234, 16'h0000, 16'h8000, 16'h0005,
                              16'hABCD, 16'h0000, 16'hFFFF, 16'h5A5A};
    logic [W-1:0] bv  [8] = '{16'h0034, 16'h0001, 16'h0001, 16'h0003,
                              16'hABCD, 16'h0000, 16'hFFFF, 16'h5A5A};
    logic         biv [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] edv [8] = '{16'h1200, 16'hFFFF, 16'h7FFF, 16'h0001,
                              16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
    logic         ebv [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic         ezv [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         eov [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int           lat;
    logic [W-1:0] d;
    logic         bo, z, ov;
    for (int i = 0; i < 8; i++) begin
      run_one(av[i], bv[i], biv[i], lat, d, bo, z, ov);
      tests++;
      if (lat !== 4 || d !== edv[i] || bo !== ebv[i]) begin
        fails++;
        $display("FAIL vec%0d: lat=%0d Diff=%h Bout=%b, want 4 %h %b",
                 i, lat, d, bo, edv[i], ebv[i]);
      end
`ifdef SUB_FLAGS_EN
      tests++;
      if (z !== ezv[i] || ov !== eov[i]) begin
        fails++;
        $display("FAIL flags%0d: Zero=%b Ovf=%b, want %b %b", i, z, ov, ezv[i], eov[i]);
      end
`else
      if (z !== 1'b0 || ov !== 1'b0 || ezv[i] === 1'bx || eov[i] === 1'bx) begin
        tests++;
        fails++;
        $display("FAIL flags%0d: unexpected flag values", i);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av [16] = '{16'h0001, 16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000,
                              16'hDEAD, 16'h00FF, 16'hF000, 16'h0F0F, 16'h1111, 16'hA5A5,
                              16'h0010, 16'hC000, 16'h4321, 16'h9999};
    logic [W-1:0] bv [16] = '{16'h0002, 16'h1234, 16'h0001, 16'h8001, 16'hFFFF, 16'h0000,
                              16'hBEEF, 16'h0100, 16'h0FFF, 16'hF0F0, 16'h1111, 16'h5A5A,
                              16'h0001, 16'h4000, 16'h1234, 16'h6666};
    logic         popped, extra;
    logic [W:0]   got, exp;
    int           npop = 0, first = -1, last = -1, cyc = 0;
    q.delete();
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, av[i], bv[i], logic'(i % 3 == 1), 1'b1, popped, extra, got, exp);
      if (popped) begin
        tests++; npop++;
        if (first < 0) first = cyc;
        last = cyc;
        if (extra || got !== exp) begin
          fails++;
          $display("FAIL b2b_data: got %h want %h extra=%b", got, exp, extra);
        end
      end
      cyc++;
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, popped, extra, got, exp);
      if (popped) begin
        tests++; npop++;
        if (first < 0) first = cyc;
        last = cyc;
        if (extra || got !== exp) begin
          fails++;
          $display("FAIL b2b_data: got %h want %h extra=%b", got, exp, extra);
        end
      end
      cyc++;
    end
    tests++;
    if (npop != 16 || last - first != 15 || q.size() != 0) begin
      fails++;
      $display("FAIL b2b_stream: pops=%0d span=%0d left=%0d, want 16 15 0",
               npop, last - first, q.size());
    end
  endtask

  task automatic test_stall();
    logic         popped, extra;
    logic [W:0]   got, exp;
    int           npush_before;
    q.delete();
    for (int i = 0; i < 4; i++)
      drive_cycle(1'b1, 16'h3000 + 16'(i * 16'h0111), 16'h0F00 + 16'(i), 1'b0, 1'b0,
                  popped, extra, got, exp);
    for (int i = 0; i < 5; i++) begin
      npush_before = q.size();
      drive_cycle(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, popped, extra, got, exp);
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {Bout, Diff} !== q[0] ||
          q.size() != npush_before) begin
        fails++;
        $display("FAIL stall: in_ready=%b out_valid=%b out=%h want 0 1 %h",
                 in_ready, out_valid, {Bout, Diff}, q[0]);
      end
    end
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0),
                  popped, extra, got, exp);
      if (popped) begin
        tests++;
        if (extra || got !== exp) begin
          fails++;
          $display("FAIL stall_stream: got %h want %h extra=%b", got, exp, extra);
        end
      end
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, popped, extra, got, exp);
      if (popped) begin
        tests++;
        if (extra || got !== exp) begin
          fails++;
          $display("FAIL stall_drain: got %h want %h extra=%b", got, exp, extra);
        end
      end
    end
    tests++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_empty: left=%0d out_valid=%b, want 0 0", q.size(), out_valid);
    end
  endtask

  task automatic test_flush();
    logic         popped, extra;
    logic [W:0]   got, exp;
    q.delete();
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, 16'h4444, 16'h1111 + 16'(i), 1'b0, 1'b1, popped, extra, got, exp);
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    q.delete();
    tests++;
    if (out_valid !== 1'b0 || Diff !== 16'h0000 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush: out_valid=%b Diff=%h in_ready=%b, want 0 0000 1",
               out_valid, Diff, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, popped, extra, got, exp);
      tests++;
      if (popped) begin
        fails++;
        $display("FAIL flush_stale: out_valid=1 Diff=%h, want no output", Diff);
      end
    end
  endtask

  initial begin
    test_reset();
    test_boundary();
    test_back_to_back();
    test_stall();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
